// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bufpipe_pkg.sv
// Shared constants and helpers for the elastic buffer pipeline.
// occ_w() sizes the occupancy counter so it can hold 0..2*depth.
package gf180mcu_fd_sc_mcu7t5v0__bufpipe_pkg;

    localparam int DEPTH_MAX = 16;

    function automatic int occ_w(input int depth);
        int w;
        w = $clog2(2 * depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bufpipe_stage.sv
// One 2-entry skid stage: a main register drives the output, and a skid register
// catches the word in flight when downstream stalls.
module gf180mcu_fd_sc_mcu7t5v0__bufpipe_stage
    import gf180mcu_fd_sc_mcu7t5v0__bufpipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_d,
    input  logic             in_v,
    output logic             in_rdy,
    output logic [WIDTH-1:0] out_d,
    output logic             out_v,
    input  logic             out_rdy
);

    logic             m_v;
    logic             s_v;
    logic [WIDTH-1:0] m_d;
    logic [WIDTH-1:0] s_d;

    // Ready depends only on the skid flop, so Z_READY never reaches I_READY combinationally.
    // The main data register only loads on a real word, so the output holds its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
            m_d <= '0;
            s_d <= '0;
        end else if (!m_v || out_rdy) begin
            if (s_v) begin
                m_v <= 1'b1;
                m_d <= s_d;
                s_v <= 1'b0;
            end else begin
                m_v <= in_v;
                if (in_v) begin
                    m_d <= in_d;
                end
            end
        end else if (in_v && !s_v) begin
            s_d <= in_d;
            s_v <= 1'b1;
        end
    end

    assign in_rdy = !s_v;
    assign out_v  = m_v;
    assign out_d  = m_d;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bufpipe.sv
// Elastic valid/ready buffer: DEPTH chained skid stages plus an occupancy counter.
// DEPTH=0 collapses to plain wires.
module gf180mcu_fd_sc_mcu7t5v0__bufpipe
    import gf180mcu_fd_sc_mcu7t5v0__bufpipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
`ifdef USE_POWER_PINS
    inout  wire                      VDD,
    inout  wire                      VSS,
`endif
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         I,
    input  logic                     I_VALID,
    output logic                     I_READY,
    output logic [WIDTH-1:0]         Z,
    output logic                     Z_VALID,
    input  logic                     Z_READY,
    output logic [occ_w(DEPTH)-1:0]  OCC
);

    localparam int OW = occ_w(DEPTH);

    if (DEPTH < 0 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("bufpipe: DEPTH out of range");
    end

    if (DEPTH == 0) begin : g_wire
        logic unused_clkrst;

        assign Z             = I;
        assign Z_VALID       = I_VALID;
        assign I_READY       = Z_READY;
        assign OCC           = '0;
        assign unused_clkrst = CLK ^ RST;
    end else begin : g_pipe
        logic [WIDTH-1:0] d [DEPTH+1];
        logic [DEPTH:0]   v;
        logic [DEPTH:0]   r;
        logic [OW-1:0]    occ;
        logic             in_xfer;
        logic             out_xfer;

        assign d[0]     = I;
        assign v[0]     = I_VALID;
        assign I_READY  = r[0];
        assign Z        = d[DEPTH];
        assign Z_VALID  = v[DEPTH];
        assign r[DEPTH] = Z_READY;

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            gf180mcu_fd_sc_mcu7t5v0__bufpipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk     (CLK),
                .rst     (RST),
                .in_d    (d[k]),
                .in_v    (v[k]),
                .in_rdy  (r[k]),
                .out_d   (d[k+1]),
                .out_v   (v[k+1]),
                .out_rdy (r[k+1])
            );
        end

        assign in_xfer  = I_VALID & r[0];
        assign out_xfer = v[DEPTH] & Z_READY;

        // Counts words in flight; capacity bounds it at 2*DEPTH so it cannot wrap.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                occ <= '0;
            end else if (in_xfer && !out_xfer) begin
                occ <= occ + 1'b1;
            end else if (!in_xfer && out_xfer) begin
                occ <= occ - 1'b1;
            end
        end

        assign OCC = occ;
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__bufpipe.sv
// Bench for the elastic buffer: a FIFO scoreboard checks a DEPTH=2 instance under
// random backpressure, and a DEPTH=0 instance is checked as a pure wire.
module tb_gf180mcu_fd_sc_mcu7t5v0__bufpipe;

    typedef struct {
        logic [7:0] data;
        int         cycle;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] iData;
    logic       iValid;
    logic       iReady;
    logic [7:0] zData;
    logic       zValid;
    logic       zReady;
    logic [2:0] occ;

    logic [3:0] iData0;
    logic       iValid0;
    logic       iReady0;
    logic [3:0] zData0;
    logic       zValid0;
    logic       zReady0;
    logic [0:0] occ0;

    entry_t     sbq[$];
    int         checks = 0;
    int         failures = 0;
    int         cycle = 0;
    int         accTotal = 0;
    int         delTotal = 0;
    bit         latencyCheck = 0;
    bit         prevStall = 0;
    logic [7:0] prevZ;

    gf180mcu_fd_sc_mcu7t5v0__bufpipe #(.WIDTH(8), .DEPTH(2)) dut (
        .CLK     (clk),
        .RST     (rst),
        .I       (iData),
        .I_VALID (iValid),
        .I_READY (iReady),
        .Z       (zData),
        .Z_VALID (zValid),
        .Z_READY (zReady),
        .OCC     (occ)
    );

    gf180mcu_fd_sc_mcu7t5v0__bufpipe #(.WIDTH(4), .DEPTH(0)) dut0 (
        .CLK     (clk),
        .RST     (rst),
        .I       (iData0),
        .I_VALID (iValid0),
        .I_READY (iReady0),
        .Z       (zData0),
        .Z_VALID (zValid0),
        .Z_READY (zReady0),
        .OCC     (occ0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer one word and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [7:0] w);
        int guard = 0;
        iData  = w;
        iValid = 1'b1;
        @(negedge clk);
        while (!iReady && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checkOutput("accept_timeout", 32'(guard), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: FIFO reference model of capacity 4, sampled mid-cycle between edges.
    always @(negedge clk) begin
        entry_t e;
        cycle++;
        if (rst) begin
            sbq.delete();
            prevStall = 0;
        end else begin
            if (prevStall) begin
                checkOutput("z_valid_held", {31'd0, zValid}, 32'd1);
                checkOutput("z_stable", {24'd0, zData}, {24'd0, prevZ});
            end
            checkOutput("occ_vs_model", {29'd0, occ}, 32'(sbq.size()));
            if (sbq.size() == 4) checkOutput("i_ready_full", {31'd0, iReady}, 32'd0);
            if (sbq.size() == 0) checkOutput("i_ready_empty", {31'd0, iReady}, 32'd1);
            if (zValid && zReady) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_word", {24'd0, zData}, 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("z_data", {24'd0, zData}, {24'd0, e.data});
                    if (latencyCheck) checkOutput("latency", 32'(cycle - e.cycle), 32'd2);
                end
                delTotal++;
            end
            if (iValid && iReady) begin
                e.data  = iData;
                e.cycle = cycle;
                sbq.push_back(e);
                accTotal++;
            end
            prevStall = zValid && !zReady;
            prevZ     = zData;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accBefore;
        int delBefore;

        // Reset with traffic present, then an asynchronous reset mid-stream
        rst     = 1'b1;
        iData   = 8'h3C;
        iValid  = 1'b1;
        zReady  = 1'b1;
        iData0  = 4'h0;
        iValid0 = 1'b0;
        zReady0 = 1'b0;
        waitCycles(2);
        checkOutput("rst_z_valid", {31'd0, zValid}, 32'd0);
        checkOutput("rst_z", {24'd0, zData}, 32'd0);
        checkOutput("rst_i_ready", {31'd0, iReady}, 32'd1);
        checkOutput("rst_occ", {29'd0, occ}, 32'd0);
        iValid = 1'b0;
        rst    = 1'b0;
        waitCycles(1);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        iValid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_z_valid", {31'd0, zValid}, 32'd0);
        checkOutput("async_rst_z", {24'd0, zData}, 32'd0);
        checkOutput("async_rst_occ", {29'd0, occ}, 32'd0);
        checkOutput("async_rst_i_ready", {31'd0, iReady}, 32'd1);
        waitCycles(2);
        rst = 1'b0;
        waitCycles(1);

        // Back-to-back stream with no stalls: fixed latency of two cycles
        latencyCheck = 1;
        zReady = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(8'(i));
            if (i == 8) checkOutput("occ_streaming", {29'd0, occ}, 32'd2);
        end
        iValid = 1'b0;
        waitCycles(4);
        latencyCheck = 0;
        checkOutput("stream_drained", {29'd0, occ}, 32'd0);

        // Fill with output stalled: exactly four words fit
        zReady    = 1'b0;
        accBefore = accTotal;
        repeat (8) begin
            iData  = 8'($urandom);
            iValid = 1'b1;
            waitCycles(1);
        end
        checkOutput("fill_accepted", 32'(accTotal - accBefore), 32'd4);
        checkOutput("fill_i_ready", {31'd0, iReady}, 32'd0);
        checkOutput("fill_occ", {29'd0, occ}, 32'd4);
        iValid = 1'b0;
        zReady = 1'b1;
        waitCycles(1);
        checkOutput("i_ready_after_first_pop", {31'd0, iReady}, 32'd0);
        waitCycles(1);
        checkOutput("i_ready_one_cycle_later", {31'd0, iReady}, 32'd1);
        waitCycles(6);
        checkOutput("drain_occ", {29'd0, occ}, 32'd0);

        // Full buffer with random backpressure, then random valid as well
        zReady = 1'b0;
        repeat (6) begin
            iData  = 8'($urandom);
            iValid = 1'b1;
            waitCycles(1);
        end
        repeat (1000) begin
            iData  = 8'($urandom);
            iValid = 1'b1;
            zReady = 1'($urandom_range(0, 1));
            waitCycles(1);
        end
        repeat (300) begin
            iData  = 8'($urandom);
            iValid = 1'($urandom_range(0, 1));
            zReady = 1'($urandom_range(0, 1));
            waitCycles(1);
        end
        iValid = 1'b0;
        zReady = 1'b1;
        waitCycles(10);
        checkOutput("random_drained_occ", {29'd0, occ}, 32'd0);
        checkOutput("random_drained_model", 32'(sbq.size()), 32'd0);

        // Reset at occupancy 3: nothing held may resurface afterwards
        zReady = 1'b0;
        applyStimulus(8'h5A);
        applyStimulus(8'h6B);
        applyStimulus(8'h7C);
        iValid = 1'b0;
        checkOutput("occ_before_reset", {29'd0, occ}, 32'd3);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_occ", {29'd0, occ}, 32'd0);
        checkOutput("midrst_z_valid", {31'd0, zValid}, 32'd0);
        waitCycles(2);
        rst    = 1'b0;
        zReady = 1'b1;
        waitCycles(1);
        delBefore = delTotal;
        applyStimulus(8'hA5);
        iValid = 1'b0;
        waitCycles(5);
        checkOutput("post_reset_deliveries", 32'(delTotal - delBefore), 32'd1);
        checkOutput("post_reset_model_empty", 32'(sbq.size()), 32'd0);

        // DEPTH=0 instance behaves as wires
        iData0  = 4'h9;
        iValid0 = 1'b1;
        zReady0 = 1'b0;
        #1;
        checkOutput("d0_z", {28'd0, zData0}, 32'h9);
        checkOutput("d0_z_valid", {31'd0, zValid0}, 32'd1);
        checkOutput("d0_i_ready", {31'd0, iReady0}, 32'd0);
        checkOutput("d0_occ", {31'd0, occ0}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            iData0  = 4'($urandom);
            iValid0 = 1'($urandom_range(0, 1));
            zReady0 = 1'($urandom_range(0, 1));
            #1;
            checkOutput("d0_rand_z", {28'd0, zData0}, {28'd0, iData0});
            checkOutput("d0_rand_valid", {31'd0, zValid0}, {31'd0, iValid0});
            checkOutput("d0_rand_ready", {31'd0, iReady0}, {31'd0, zReady0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
